decode_stage: RTL and testbench

Instruction-decode stage of the 16-bit-instruction / 32-bit-datapath pipeline, sitting directly upstream of the execute stage. It holds the 16×32 register file, decodes each instruction into the control signals execute consumes, and detects load-use hazards with a one-bubble stall. It also captures everything into the ID/EX pipeline register and honours the flush issued by execute on a taken branch/jump.

---
 rtl/decode_stage_pkg.sv | 35 +++
 rtl/decode_stage_if.sv | 25 ++
 rtl/decode_stage_regfile.sv | 24 ++
 rtl/decode_stage.sv | 66 ++++++
 tb/tb_decode_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcodes, ALU encodings, field positions and ID/EX control bundle shared with execute
package decode_stage_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5, OP_LD = 4'h6, OP_ST = 4'h7, OP_BEQ = 4'h8, OP_JMP = 4'h9;
  localparam int OP_MSB = 15, RQ_MSB = 11, RS_MSB = 7;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_PASS} alu_op_t;
  typedef struct packed {
    logic    jump_or_branch_high;
    logic    rqrd_or_imm;
    logic    rs_or_imm;
    alu_op_t alu_ctrl;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_wr;
    logic    illegal;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP: c.illegal = 1'b0;
      OP_ADD: begin c.alu_ctrl = ALU_ADD; c.reg_wr = 1'b1; end
      OP_SUB: begin c.alu_ctrl = ALU_SUB; c.reg_wr = 1'b1; end
      OP_AND: begin c.alu_ctrl = ALU_AND; c.reg_wr = 1'b1; end
      OP_OR: begin c.alu_ctrl = ALU_OR; c.reg_wr = 1'b1; end
      OP_ADDI: begin c.rs_or_imm = 1'b1; c.reg_wr = 1'b1; end
      OP_LD: begin c.rs_or_imm = 1'b1; c.mem_rd = 1'b1; c.reg_wr = 1'b1; end
      OP_ST: begin c.rs_or_imm = 1'b1; c.mem_wr = 1'b1; end
      OP_BEQ: begin c.alu_ctrl = ALU_SUB; c.jump_or_branch_high = 1'b1; end
      OP_JMP: begin c.alu_ctrl = ALU_PASS; c.jump_or_branch_high = 1'b1; c.rqrd_or_imm = 1'b1; c.rs_or_imm = 1'b1; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID, write-back and ID/EX signals of the decode stage
interface decode_stage_if #(parameter int PC_W = 16);
  logic [PC_W-1:0] pc_in;
  logic [15:0] instr_in;
  logic valid_in, flush, wb_en;
  logic [3:0] wb_addr;
  logic [31:0] wb_data;
  logic stall;
  logic [PC_W-1:0] pc_out;
  logic [15:0] instr_out;
  logic [31:0] rqrd_out, rs_out;
  logic valid_out, jump_or_branch_high, rqrd_or_imm, rs_or_imm;
  logic [2:0] alu_ctrl;
  logic mem_rd, mem_wr, reg_wr, illegal;
  modport master (
    output pc_in, instr_in, valid_in, flush, wb_en, wb_addr, wb_data,
    input stall, pc_out, instr_out, rqrd_out, rs_out, valid_out, jump_or_branch_high,
    input rqrd_or_imm, rs_or_imm, alu_ctrl, mem_rd, mem_wr, reg_wr, illegal
  );
  modport slave (
    input pc_in, instr_in, valid_in, flush, wb_en, wb_addr, wb_data,
    output stall, pc_out, instr_out, rqrd_out, rs_out, valid_out, jump_or_branch_high,
    output rqrd_or_imm, rs_or_imm, alu_ctrl, mem_rd, mem_wr, reg_wr, illegal
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile: 2R1W register file, r0 hardwired to zero, write-through under DECODE_WB_BYPASS_EN
module decode_stage_regfile #(
  parameter int NREG = 16
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  output logic [31:0] rda,
  output logic [31:0] rdb
);
  logic [31:0] mem [NREG];
  // write port; r0 is never stored
  always_ff @(posedge clk) if (we && wa != 4'd0) mem[wa] <= wd;
`ifdef DECODE_WB_BYPASS_EN
  assign rda = ra == 4'd0 ? '0 : (we && wa == ra) ? wd : mem[ra];
  assign rdb = rb == 4'd0 ? '0 : (we && wa == rb) ? wd : mem[rb];
`else
  assign rda = ra == 4'd0 ? '0 : mem[ra];
  assign rdb = rb == 4'd0 ? '0 : mem[rb];
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: register file, decode, load-use stall and ID/EX register (option DECODE_WB_BYPASS_EN)
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int NREG = 16
) (
  input logic clk,
  input logic rst,
  decode_stage_if.slave d
);
  logic [3:0] op, rq, rs, ex_rd;
  logic [31:0] rda, rdb, rq_q, rs_q;
  logic use_rq, use_rs, hazard, bubble, valid_q;
  ctrl_t c, ctrl_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0] instr_q;
  decode_stage_regfile #(.NREG(NREG)) u_rf (
    .clk, .we(d.wb_en), .wa(d.wb_addr), .wd(d.wb_data), .ra(rq), .rb(rs), .rda, .rdb
  );
  assign op = d.instr_in[OP_MSB -: 4];
  assign rq = d.instr_in[RQ_MSB -: 4];
  assign rs = d.instr_in[RS_MSB -: 4];
  assign ex_rd = instr_q[RQ_MSB -: 4];
  // decode and load-use detection against the LD held in ID/EX
  always_comb begin
    c = decode(op);
    use_rq = op inside {[OP_ADD:OP_BEQ]};
    use_rs = use_rq && !c.rs_or_imm;
    hazard = d.valid_in && valid_q && ctrl_q.mem_rd && ex_rd != 4'd0 &&
             ((use_rq && rq == ex_rd) || (use_rs && rs == ex_rd));
    bubble = !d.valid_in || d.flush || hazard;
  end
  assign d.stall = hazard && !d.flush && !rst;
  // ID/EX register; bubbles zero the control bundle while data is still captured
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      instr_q <= '0;
      rq_q <= '0;
      rs_q <= '0;
      valid_q <= 1'b0;
      ctrl_q <= '0;
    end else begin
      pc_q <= d.pc_in;
      instr_q <= d.instr_in;
      rq_q <= rda;
      rs_q <= rdb;
      valid_q <= !bubble;
      ctrl_q <= bubble ? '0 : c;
    end
  end
  assign d.pc_out = pc_q;
  assign d.instr_out = instr_q;
  assign d.rqrd_out = rq_q;
  assign d.rs_out = rs_q;
  assign d.valid_out = valid_q;
  assign d.jump_or_branch_high = ctrl_q.jump_or_branch_high;
  assign d.rqrd_or_imm = ctrl_q.rqrd_or_imm;
  assign d.rs_or_imm = ctrl_q.rs_or_imm;
  assign d.alu_ctrl = ctrl_q.alu_ctrl;
  assign d.mem_rd = ctrl_q.mem_rd;
  assign d.mem_wr = ctrl_q.mem_wr;
  assign d.reg_wr = ctrl_q.reg_wr;
  assign d.illegal = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized run against a spec-level reference model
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] rf [16];
  logic [10:0] ctl_obs;
  decode_stage_if #(.PC_W(16)) bus ();
  decode_stage #(.PC_W(16), .NREG(16)) dut (.clk(clk), .rst(rst), .d(bus));
  always #5 clk = ~clk;
  assign ctl_obs = {bus.valid_out, bus.jump_or_branch_high, bus.rqrd_or_imm, bus.rs_or_imm,
                    bus.alu_ctrl, bus.mem_rd, bus.mem_wr, bus.reg_wr, bus.illegal};
  function automatic logic [10:0] exp_ctl(input logic v, input logic [3:0] op);
    logic [2:0] alu;
    if (!v) return '0;
    alu = (op == 4'h2 || op == 4'h8) ? 3'd1 : op == 4'h3 ? 3'd2 : op == 4'h4 ? 3'd3 : op == 4'h9 ? 3'd4 : 3'd0;
    return {1'b1, op == 4'h8 || op == 4'h9, op == 4'h9, op inside {4'h5, 4'h6, 4'h7, 4'h9}, alu,
            op == 4'h6, op == 4'h7, op inside {[4'h1:4'h6]}, op >= 4'hA};
  endfunction
  function automatic logic [31:0] rd_model(input logic [3:0] a, input logic we, input logic [3:0] wa, input logic [31:0] wd);
    if (a == 4'd0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return rf[a];
  endfunction
  task automatic idle();
    bus.valid_in = 1'b0;
    bus.flush = 1'b0;
    bus.wb_en = 1'b0;
    bus.instr_in = '0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    idle();
    bus.wb_en = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = v;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
    if (a != 4'd0) rf[a] = v;
  endtask
  task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
    bus.instr_in = ins;
    bus.pc_in = pc;
    bus.valid_in = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({ctl_obs, bus.pc_out, bus.instr_out, bus.rqrd_out, bus.rs_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs ctl=%h pc=%h instr=%h rq=%h rs=%h, required all 0", ctl_obs, bus.pc_out, bus.instr_out, bus.rqrd_out, bus.rs_out);
    end
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b required 0", bus.stall); end
  endtask
  task automatic test_add();
    wr(1, 32'h11); wr(2, 32'd5); wr(3, 32'd7);
    issue(16'h1123, 16'h0040);
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL add_stall got %b required 0", bus.stall); end
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== exp_ctl(1'b1, 4'h1)) begin n_fail++; $display("FAIL add_ctl got %h required %h", ctl_obs, exp_ctl(1'b1, 4'h1)); end
    n_chk++;
    if ({bus.rqrd_out, bus.rs_out} !== {32'h11, 32'd5}) begin n_fail++; $display("FAIL add_data got %h/%h required 11/5", bus.rqrd_out, bus.rs_out); end
    n_chk++;
    if ({bus.pc_out, bus.instr_out} !== {16'h0040, 16'h1123}) begin n_fail++; $display("FAIL add_pc_instr got %h/%h required 0040/1123", bus.pc_out, bus.instr_out); end
    idle();
  endtask
  task automatic test_load_use();
    wr(4, 32'hA5A5_0004); wr(5, 32'h0000_0555);
    issue(16'h6400, 16'h0010);
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== exp_ctl(1'b1, 4'h6)) begin n_fail++; $display("FAIL ld_ctl got %h required %h", ctl_obs, exp_ctl(1'b1, 4'h6)); end
    issue(16'h1541, 16'h0011);
    #1;
    n_chk++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b required 1", bus.stall); end
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== '0) begin n_fail++; $display("FAIL lu_bubble got %h required 0", ctl_obs); end
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_single_stall got %b required 0", bus.stall); end
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== exp_ctl(1'b1, 4'h1)) begin n_fail++; $display("FAIL lu_issue_ctl got %h required %h", ctl_obs, exp_ctl(1'b1, 4'h1)); end
    n_chk++;
    if ({bus.rqrd_out, bus.rs_out, bus.pc_out} !== {32'h555, 32'hA5A5_0004, 16'h0011}) begin
      n_fail++; $display("FAIL lu_issue_data got %h/%h/%h required 555/a5a50004/0011", bus.rqrd_out, bus.rs_out, bus.pc_out);
    end
    idle();
  endtask
  task automatic test_flush_hazard();
    issue(16'h6400, 16'h0020);
    @(posedge clk); #1;
    issue(16'h1541, 16'h0021);
    bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b required 0", bus.stall); end
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== '0) begin n_fail++; $display("FAIL flush_bubble got %h required 0", ctl_obs); end
    idle();
    @(posedge clk); #1;
  endtask
  task automatic test_wb_bypass();
    logic [31:0] old;
    old = rf[3];
    issue(16'h1132, 16'h0030);
    bus.wb_en = 1'b1;
    bus.wb_addr = 4'd3;
    bus.wb_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rf[3] = 32'hDEAD_BEEF;
    bus.wb_en = 1'b0;
    n_chk++;
`ifdef DECODE_WB_BYPASS_EN
    if (bus.rs_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wb_same_cycle got %h required deadbeef", bus.rs_out); end
`else
    if (bus.rs_out !== old) begin n_fail++; $display("FAIL wb_same_cycle got %h required %h", bus.rs_out, old); end
`endif
    @(posedge clk); #1;
    n_chk++;
    if (bus.rs_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wb_next_cycle got %h required deadbeef", bus.rs_out); end
    idle();
  endtask
  task automatic test_r0();
    wr(0, 32'h1234);
    issue(16'h1000, 16'h0050);
    @(posedge clk); #1;
    n_chk++;
    if ({bus.rqrd_out, bus.rs_out} !== 64'd0) begin n_fail++; $display("FAIL r0_read got %h/%h required 0/0", bus.rqrd_out, bus.rs_out); end
    idle();
  endtask
  task automatic test_illegal();
    issue(16'hB123, 16'h0060);
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== 11'b1_0_0_0_000_0_0_0_1) begin n_fail++; $display("FAIL illegal_ctl got %b required 10000000001", ctl_obs); end
    idle();
  endtask
  task automatic test_reset_mid_stall();
    issue(16'h6400, 16'h0070);
    @(posedge clk); #1;
    issue(16'h1541, 16'h0071);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({ctl_obs, bus.pc_out, bus.instr_out} !== '0) begin n_fail++; $display("FAIL rst_stall_clear got %h/%h/%h required 0", ctl_obs, bus.pc_out, bus.instr_out); end
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_no_stall got %b required 0", bus.stall); end
    @(posedge clk); #1;
    n_chk++;
    if (ctl_obs !== exp_ctl(1'b1, 4'h1)) begin n_fail++; $display("FAIL rst_no_bubble got %h required %h", ctl_obs, exp_ctl(1'b1, 4'h1)); end
    idle();
  endtask
  task automatic test_random();
    logic [15:0] ins, pc;
    logic vin, fl, we, hz, es, hold, m_v, m_ld;
    logic [3:0] op, rq, rs, wa, m_rd;
    logic [31:0] wd, ea, eb;
    for (int r = 1; r < 5; r++) wr(4'(r), $urandom);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_v = 1'b0; m_ld = 1'b0; m_rd = '0; hold = 1'b0;
    ins = '0; pc = '0; vin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom)};
        pc = 16'($urandom);
        vin = $urandom_range(0, 3) != 0;
      end
      fl = $urandom_range(0, 7) == 0;
      we = $urandom_range(0, 3) == 0;
      wa = 4'($urandom_range(0, 4));
      wd = $urandom;
      bus.instr_in = ins; bus.pc_in = pc; bus.valid_in = vin; bus.flush = fl;
      bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
      op = ins[15:12]; rq = ins[11:8]; rs = ins[7:4];
      hz = vin && m_v && m_ld && m_rd != 4'd0 &&
           ((op inside {[4'h1:4'h8]} && rq == m_rd) || (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h8} && rs == m_rd));
      es = hz && !fl;
      ea = rd_model(rq, we, wa, wd);
      eb = rd_model(rs, we, wa, wd);
      #1;
      n_chk++;
      if (bus.stall !== es) begin n_fail++; $display("FAIL rnd_stall[%0d] got %b required %b", i, bus.stall, es); end
      @(posedge clk); #1;
      m_v = vin && !fl && !hz; m_ld = op == 4'h6; m_rd = rq;
      if (we && wa != 4'd0) rf[wa] = wd;
      n_chk++;
      if (ctl_obs !== exp_ctl(m_v, op)) begin n_fail++; $display("FAIL rnd_ctl[%0d] got %h required %h", i, ctl_obs, exp_ctl(m_v, op)); end
      if (m_v) begin
        n_chk++;
        if ({bus.pc_out, bus.instr_out, bus.rqrd_out, bus.rs_out} !== {pc, ins, ea, eb}) begin
          n_fail++; $display("FAIL rnd_data[%0d] got %h/%h/%h/%h required %h/%h/%h/%h", i, bus.pc_out, bus.instr_out, bus.rqrd_out, bus.rs_out, pc, ins, ea, eb);
        end
      end
      hold = es;
    end
    idle();
  endtask
  initial begin
    idle();
    bus.pc_in = '0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    test_reset();
    test_add();
    test_load_use();
    test_flush_hazard();
    test_wb_bypass();
    test_r0();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
